// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared types, defaults and helpers for the convolution arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int c_DEF_DATA_WIDTH  = 32;
    localparam int c_DEF_KERNEL_SIZE = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Ceiling log2, never below 1 so single-bit indices stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_accel_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module  : rr_select
// Brief   : Combinational round-robin picker: first valid at or above rr_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_select
    import conv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    (i == ((int'(rr_ptr) + off) % NUM_REQ))) begin
                    w_found   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_accel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : conv_accel_arbiter
// Brief   : Round-robin sharing of one matrix accelerator with watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module conv_accel_arbiter
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = c_DEF_KERNEL_SIZE,
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                                                 axi_clk,
    input  logic                                                 axi_reset_n,
    input  logic [NUM_REQ-1:0]                                   req_valid,
    output logic [NUM_REQ-1:0]                                   req_ready,
    input  logic [NUM_REQ*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] req_multiplier,
    input  logic [NUM_REQ*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] req_multiplicand,
    output logic [NUM_REQ-1:0]                                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                                rsp_sum,
    output logic                                                 rsp_error,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]        acc_multiplier_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]        acc_multiplicand_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                   acc_mstart,
    input  logic [DATA_WIDTH-1:0]                                acc_sum,
    input  logic                                                 acc_ready,
    output logic                                                 busy,
    output logic [clog2(NUM_REQ)-1:0]                            grant_id
);

    localparam int c_N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_W     = c_N * DATA_WIDTH;
    localparam int c_IDX_W = clog2(NUM_REQ);
    localparam int c_CNT_W = clog2(TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    r_grant_id;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic [NUM_REQ-1:0]    w_sel_grant;
    logic [c_W-1:0]        r_mult;
    logic [c_W-1:0]        r_mcand;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_error;
    logic                  r_acc_ready_q;
    logic [c_CNT_W-1:0]    r_wdog;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic [c_W-1:0]        w_mult_slice  [NUM_REQ];
    logic [c_W-1:0]        w_mcand_slice [NUM_REQ];

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_select (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_sel_grant),
        .grant_idx (w_sel_idx)
    );

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
            assign w_mult_slice[i]  = req_multiplier[i*c_W +: c_W];
            assign w_mcand_slice[i] = req_multiplicand[i*c_W +: c_W];
        end
    endgenerate

    // Only a fresh rising edge completes; a level left over from before is ignored.
    assign w_done    = acc_ready & ~r_acc_ready_q;
    assign w_timeout = (r_wdog == c_CNT_W'(TIMEOUT));

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        acc_mstart  = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = axi_reset_n ? w_sel_grant : '0;
                w_accept  = |w_sel_grant;
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                acc_mstart  = '1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_mult        <= '0;
            r_mcand       <= '0;
            r_sum         <= '0;
            r_error       <= 1'b0;
            r_acc_ready_q <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_acc_ready_q <= acc_ready;
            r_wdog        <= (r_state == ST_WAIT) ? r_wdog + 1'b1 : '0;
            if (w_accept) begin
                r_grant_id <= w_sel_idx;
                r_mult     <= w_mult_slice[w_sel_idx];
                r_mcand    <= w_mcand_slice[w_sel_idx];
            end
            if (r_state == ST_WAIT) begin
                if (w_done) begin
                    r_sum   <= acc_sum;
                    r_error <= 1'b0;
                end else if (w_timeout) begin
                    r_sum   <= '0;
                    r_error <= 1'b1;
                end
            end
            if (r_state == ST_RESPOND) begin
                r_rr_ptr <= (r_grant_id == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
            assign rsp_valid[i] = (r_state == ST_RESPOND) && (r_grant_id == c_IDX_W'(i));
        end
    endgenerate

    assign rsp_sum                = r_sum;
    assign rsp_error              = r_error;
    assign acc_multiplier_input   = r_mult;
    assign acc_multiplicand_input = r_mcand;
    assign busy                   = (r_state != ST_IDLE);
    assign grant_id               = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_conv_accel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_accel_arbiter
// Brief   : Directed self-checking bench for conv_accel_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conv_accel_arbiter;

    localparam int c_DW = 32;
    localparam int c_KS = 3;
    localparam int c_NR = 2;
    localparam int c_W  = c_KS * c_KS * c_DW;

    logic                   axi_clk;
    logic                   axi_reset_n;
    logic [c_NR-1:0]        req_valid;
    logic [c_NR-1:0]        req_ready;
    logic [c_NR*c_W-1:0]    req_multiplier;
    logic [c_NR*c_W-1:0]    req_multiplicand;
    logic [c_NR-1:0]        rsp_valid;
    logic [c_DW-1:0]        rsp_sum;
    logic                   rsp_error;
    logic [c_W-1:0]         acc_multiplier_input;
    logic [c_W-1:0]         acc_multiplicand_input;
    logic [c_KS*c_KS-1:0]   acc_mstart;
    logic [c_DW-1:0]        acc_sum;
    logic                   acc_ready;
    logic                   busy;
    logic [0:0]             grant_id;

    logic [c_W-1:0] data_a, filt_a, data_b, filt_b;
    int n_tests;
    int n_fail;

    conv_accel_arbiter #(
        .DATA_WIDTH  (c_DW),
        .KERNEL_SIZE (c_KS),
        .NUM_REQ     (c_NR),
        .TIMEOUT     (8)
    ) dut (
        .axi_clk                (axi_clk),
        .axi_reset_n            (axi_reset_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_multiplier         (req_multiplier),
        .req_multiplicand       (req_multiplicand),
        .rsp_valid              (rsp_valid),
        .rsp_sum                (rsp_sum),
        .rsp_error              (rsp_error),
        .acc_multiplier_input   (acc_multiplier_input),
        .acc_multiplicand_input (acc_multiplicand_input),
        .acc_mstart             (acc_mstart),
        .acc_sum                (acc_sum),
        .acc_ready              (acc_ready),
        .busy                   (busy),
        .grant_id               (grant_id)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // One full operation for requester 'who'; acc_ready must be low on entry.
    task automatic run_op(input logic [1:0] who, input logic [31:0] sum, input int lat,
                          input bit drop, input bit keep);
        #1;
        chk("op_ready", req_ready, who);
        tick();
        if (drop) req_valid = 2'b00;
        chk("op_mstart", acc_mstart, 9'h1FF);
        chk("op_busy", busy, 1'b1);
        chk("op_grant_id", grant_id, (who == 2'b10));
        chk("op_mult", acc_multiplier_input, (who == 2'b10) ? data_b : data_a);
        chk("op_mcand", acc_multiplicand_input, (who == 2'b10) ? filt_b : filt_a);
        tick();
        chk("op_mstart_off", acc_mstart, 9'h000);
        repeat (lat) tick();
        acc_ready = 1'b1;
        acc_sum   = sum;
        chk("op_no_early", rsp_valid, 2'b00);
        tick();
        chk("op_rsp_valid", rsp_valid, who);
        chk("op_rsp_sum", rsp_sum, sum);
        chk("op_rsp_error", rsp_error, 1'b0);
        if (!keep) acc_ready = 1'b0;
        tick();
        chk("op_rsp_drop", rsp_valid, 2'b00);
        chk("op_idle", busy, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int k = 0; k < 9; k++) begin
            data_a[k*c_DW +: c_DW] = 32'(k);
            filt_a[k*c_DW +: c_DW] = 32'(k);
            data_b[k*c_DW +: c_DW] = 32'(k + 1);
            filt_b[k*c_DW +: c_DW] = 32'd2;
        end
        req_multiplier   = {data_b, data_a};
        req_multiplicand = {filt_b, filt_a};
        req_valid   = 2'b00;
        acc_ready   = 1'b0;
        acc_sum     = '0;
        axi_reset_n = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1;

        // Reset state
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_sum", rsp_sum, 32'd0);
        chk("rst_rsp_error", rsp_error, 1'b0);
        chk("rst_acc_mult", acc_multiplier_input, '0);
        chk("rst_acc_mcand", acc_multiplicand_input, '0);
        chk("rst_mstart", acc_mstart, 9'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        axi_reset_n = 1'b1;
        tick();

        // Single request: sum of k*k for k=0..8 is 204
        req_valid = 2'b01;
        run_op(2'b01, 32'd204, 3, 1'b1, 1'b0);
        chk("hold_mult", acc_multiplier_input, data_a);

        // Reset mid-WAIT on a req1 operation (pointer now at 1)
        req_valid = 2'b10;
        #1;
        chk("rstw_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("rstw_grant", grant_id, 1'b1);
        tick();
        tick();
        axi_reset_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_grant_id", grant_id, 1'b0);
        chk("rstw_acc_mult", acc_multiplier_input, '0);
        chk("rstw_rsp_valid", rsp_valid, 2'b00);
        tick();
        chk("rstw_busy_next", busy, 1'b0);
        axi_reset_n = 1'b1;
        tick();
        acc_ready = 1'b1;
        acc_sum   = 32'd55;
        tick();
        acc_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rstw_no_rsp", rsp_valid, 2'b00);
        end

        // Contention from pointer 0: grants alternate 0,1,0,1
        req_valid = 2'b11;
        run_op(2'b01, 32'd204, 3, 1'b0, 1'b0);
        run_op(2'b10, 32'd90,  2, 1'b0, 1'b0);
        run_op(2'b01, 32'd204, 1, 1'b0, 1'b0);
        run_op(2'b10, 32'd90,  4, 1'b0, 1'b0);
        req_valid = 2'b00;

        // Stale ready: acc_ready stays high into the next operation
        req_valid = 2'b01;
        run_op(2'b01, 32'd204, 2, 1'b1, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("stale_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("stale_mstart", acc_mstart, 9'h1FF);
        tick();
        tick();
        chk("stale_no_early", rsp_valid, 2'b00);
        chk("stale_busy", busy, 1'b1);
        acc_ready = 1'b0;
        tick();
        acc_ready = 1'b1;
        acc_sum   = 32'd77;
        tick();
        chk("stale_rsp_valid", rsp_valid, 2'b01);
        chk("stale_rsp_sum", rsp_sum, 32'd77);
        acc_ready = 1'b0;
        tick();

        // Timeout: no acc_ready; error response at WAIT+9
        acc_sum   = 32'hDEADBEEF;
        req_valid = 2'b01;
        #1;
        chk("to_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        repeat (8) tick();
        chk("to_not_yet", rsp_valid, 2'b00);
        chk("to_busy", busy, 1'b1);
        tick();
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_error", rsp_error, 1'b1);
        chk("to_rsp_sum", rsp_sum, 32'd0);
        tick();
        chk("to_rsp_drop", rsp_valid, 2'b00);
        req_valid = 2'b01;
        run_op(2'b01, 32'd204, 3, 1'b1, 1'b0);

        // Late requester: req1 held off during req0, then wins over new req0
        req_valid = 2'b01;
        #1;
        chk("late_ready0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b10;
        #1;
        chk("late_hold_wait", req_ready, 2'b00);
        tick();
        acc_ready = 1'b1;
        acc_sum   = 32'd204;
        #1;
        chk("late_hold_wait2", req_ready, 2'b00);
        tick();
        chk("late_rsp0", rsp_valid, 2'b01);
        chk("late_hold_rsp", req_ready, 2'b00);
        req_valid = 2'b11;
        acc_ready = 1'b0;
        #1;
        chk("late_hold_rsp2", req_ready, 2'b00);
        tick();
        chk("late_ready1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("late_grant_id", grant_id, 1'b1);
        chk("late_mult", acc_multiplier_input, data_b);
        tick();
        tick();
        acc_ready = 1'b1;
        acc_sum   = 32'd90;
        tick();
        chk("late_rsp1", rsp_valid, 2'b10);
        chk("late_rsp1_sum", rsp_sum, 32'd90);
        acc_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
